// File: rtl/controlador_jugadas.sv
// Tic-tac-toe move controller: owns the 3x3 board, validates presses, alternates turns,
// auto-plays the lowest empty cell on idle timeout and freezes once the game is decided.
module controlador_jugadas #(
  parameter int TIMEOUT_CYCLES = 500_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      celda,
  input  logic            confirmar,
  input  logic            win,
  output logic [8:0][1:0] matrizDeJuego,
  output logic            turno,
  output logic [3:0]      jugadas,
  output logic            jugada_invalida,
  output logic            timeout_evt,
  output logic            empate,
  output logic            fin_juego
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {PLAY, SETTLE, EVAL, FIN} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            conf_q;
  logic            press;
  logic            celda_free;
  logic            timeout_hit;
  logic [3:0]      libre;
  logic [1:0]      marca;

  always_comb begin
    press       = confirmar & ~conf_q;
    timeout_hit = (timer == T_LAST);
    marca       = turno ? 2'b10 : 2'b01;
    celda_free  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (celda == 4'(i) && matrizDeJuego[i] == 2'b00) celda_free = 1'b1;
    end
    // Descending scan so the lowest-index empty cell wins.
    libre = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (matrizDeJuego[i] == 2'b00) libre = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= PLAY;
      matrizDeJuego   <= '0;
      turno           <= 1'b0;
      jugadas         <= 4'd0;
      jugada_invalida <= 1'b0;
      timeout_evt     <= 1'b0;
      empate          <= 1'b0;
      fin_juego       <= 1'b0;
      timer           <= '0;
      conf_q          <= 1'b1;
    end else begin
      conf_q          <= confirmar;
      jugada_invalida <= 1'b0;
      timeout_evt     <= 1'b0;
      case (state)
        PLAY: begin
          if (win) begin
            state     <= FIN;
            fin_juego <= 1'b1;
          end else if (press && celda_free) begin
            matrizDeJuego[celda] <= marca;
            jugadas              <= jugadas + 4'd1;
            timer                <= '0;
            state                <= SETTLE;
          end else begin
            // An invalid press still pulses even if the timeout move fires in the same cycle.
            jugada_invalida <= press;
            if (timeout_hit) begin
              matrizDeJuego[libre] <= marca;
              timeout_evt          <= 1'b1;
              jugadas              <= jugadas + 4'd1;
              timer                <= '0;
              state                <= SETTLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        SETTLE: state <= EVAL;
        EVAL: begin
          if (win) begin
            state     <= FIN;
            fin_juego <= 1'b1;
          end else if (jugadas == 4'd9) begin
            state     <= FIN;
            fin_juego <= 1'b1;
            empate    <= 1'b1;
          end else begin
            turno <= ~turno;
            state <= PLAY;
          end
        end
        FIN:     state <= FIN;
        default: state <= FIN;
      endcase
    end
  end

endmodule
